pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural program counter for the unpipelined core.
- Drives the PC that the instruction fetch stage uses to address instruction memory.
- Each cycle it selects the next PC from four sources: sequential (+2), a branch/jump redirect from execute, a held value (stall), or a frozen value (halt/error).
- Keeps a retired-instruction counter and a sticky error flag for the top-level err output.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the PC this cycle (memory or hazard not ready).
- redirect_valid  input  1  execute requests a taken branch or jump.
- redirect_target  input  16  target address for the redirect.
- halt_req  input  1  decode has seen a HALT instruction at the current PC.
- pc  output  16  current PC; feeds fetch addr.
- pc_plus2  output  16  pc + 2, combinational; used by link/JAL writeback.
- halted  output  1  high in the HALTED state.
- err  output  1  sticky error flag.
- retired  output  CNT_W  count of committed PC advances.

Behaviour:
- States: RUN, HALTED, ERROR. State encoding is defined in the shared package.
- Reset (rst=1 at an edge):
  - state=RUN, pc=RESET_PC, pend_valid=0, pend_target=0, retired=0, err=0, halted=0.
  - Reset overrides every other input and applies from any state, including mid-stall with a redirect pending.
- pc_plus2 = pc + 16'd2, modulo 2^16. 0xFFFE wraps to 0x0000; the wrap does not raise err.
- Effective redirect eff_rv/eff_tgt:
  - If redirect_valid=1: eff_rv=1, eff_tgt=redirect_target.
  - Else: eff_rv=pend_valid, eff_tgt=pend_target.
- RUN with stall=1:
  - pc, retired and state hold.
  - If redirect_valid=1: pend_valid<=1, pend_target<=redirect_target. A later redirect during the same stall overwrites the earlier one.
  - halt_req is ignored while stalled.
- RUN with stall=0, priority highest first:
  1. halt_req=1: pc holds, state<=HALTED, retired+=1 (the HALT itself retires), pend_valid<=0. If a redirect arrives the same cycle, it is discarded.
  2. eff_rv=1 and eff_tgt[0]=1: misaligned target. state<=ERROR, err<=1, pc holds, retired holds, pend_valid<=0.
  3. eff_rv=1: pc<=eff_tgt, retired+=1, pend_valid<=0.
  4. Otherwise: pc<=pc_plus2, retired+=1.
- HALTED: all inputs are ignored; pc, retired and err are frozen. halted=1 combinationally from state. Only rst exits.
- ERROR: everything is frozen and err=1. Only rst exits.
- retired wraps modulo 2^CNT_W and has no saturation.
- Latency:
  - A redirect presented in a non-stalled RUN cycle appears on pc the next cycle.
  - A redirect presented during a stall appears one cycle after the first non-stalled cycle.
- All outputs except pc_plus2 and halted are registered.

Decomposition:
- Shared package (core-wide) holds:
  - state typedef/encoding: RUN=2'd0, HALTED=2'd1, ERROR=2'd2;
  - the PC width constant (16);
  - the instruction-step constant (2).
- Optional sub-module pc_incr16: 16-bit adder producing pc+2, reusable for the link-address path.
- The FSM, pending-redirect register and counter stay inline.

Test Plan:
- Reset then 4 free-running cycles, no stall -> pc = 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; retired=4; err=0, halted=0.
- pc=0x0010, redirect_valid=1, target 0x0100, stall=0 -> next pc=0x0100, retired+1. Then stall=1 for 3 cycles with redirect to 0x0200 on the 1st stall cycle -> pc stays 0x0100 through the stall, becomes 0x0200 one cycle after stall drops, with no 0x0102 in between.
- pc=0xFFFE, no redirect -> next pc=0x0000, err=0.
- halt_req=1 together with redirect_valid=1 (target 0x0040) at pc=0x0020 -> state HALTED, pc frozen at 0x0020, retired+1. 10 further cycles with redirects and stall toggling -> no change. rst=1 -> pc=0x0000, halted=0.
- redirect to 0x0031 -> err=1 next cycle, pc holds, retired holds, err sticky across following inputs. Also check via a pending path: stall=1 + redirect 0x0033, then stall=0 -> err=1.
- rst asserted during a stall with a pending redirect to 0x0300 -> after reset pc=RESET_PC, and pc advances 0x0000 → 0x0002 (the pending redirect is not applied).

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Core-wide constants and the PC sequencer state encoding.
package pc_sequencer_pkg;

   localparam int unsigned PcW = 16;
   localparam logic [PcW-1:0] PcStep = 16'd2;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StHalted = 2'd1,
      StError  = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_incr16.sv
// Sequential-address adder (pc + one instruction step), shared with the link path.
module pc_incr16
   import pc_sequencer_pkg::*;
(
   input  logic [PcW-1:0] a,
   output logic [PcW-1:0] sum
);

   // Wraps modulo 2^16; callers rely on 0xFFFE -> 0x0000 without any flag.
   assign sum = a + PcStep;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural program counter: sequential/redirect/stall/halt selection,
// retired-instruction counter and sticky error flag.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [PcW-1:0] RESET_PC = 16'h0000,
   parameter int unsigned    CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [PcW-1:0]   redirect_target,
   input  logic             halt_req,
   output logic [PcW-1:0]   pc,
   output logic [PcW-1:0]   pc_plus2,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   pc_state_e        state_q, state_d;
   logic [PcW-1:0]   pc_q, pc_d;
   logic             pend_valid_q, pend_valid_d;
   logic [PcW-1:0]   pend_target_q, pend_target_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             err_q, err_d;

   logic             eff_rv;
   logic [PcW-1:0]   eff_tgt;

   pc_incr16 u_incr (
      .a   (pc_q),
      .sum (pc_plus2)
   );

   // A live redirect beats one captured during an earlier stall.
   assign eff_rv  = redirect_valid | pend_valid_q;
   assign eff_tgt = redirect_valid ? redirect_target : pend_target_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         pc_q          <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         retired_q     <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         retired_q     <= retired_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      retired_d     = retired_q;
      err_d         = err_q;
      unique case (state_q)
         StRun: begin
            if (stall) begin
               if (redirect_valid) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = redirect_target;
               end
            end else if (halt_req) begin
               state_d      = StHalted;
               retired_d    = retired_q + CNT_W'(1);
               pend_valid_d = 1'b0;
            end else if (eff_rv && eff_tgt[0]) begin
               state_d      = StError;
               err_d        = 1'b1;
               pend_valid_d = 1'b0;
            end else if (eff_rv) begin
               pc_d         = eff_tgt;
               retired_d    = retired_q + CNT_W'(1);
               pend_valid_d = 1'b0;
            end else begin
               pc_d      = pc_plus2;
               retired_d = retired_q + CNT_W'(1);
            end
         end
         StHalted, StError: ;
         default: begin
            // Unreachable encoding: park safely in ERROR.
            state_d = StError;
            err_d   = 1'b1;
         end
      endcase
   end

   always_comb begin
      pc      = pc_q;
      retired = retired_q;
      err     = err_q;
      halted  = (state_q == StHalted);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural PC model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_target;
   logic        halt_req;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        halted;
   logic        err;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;

   // Reference model: where the program is and whether it has stopped.
   logic [15:0] m_pc;
   logic [15:0] m_ret;
   logic        m_err;
   logic        m_stopped_halt;
   logic        m_stopped_err;
   logic        m_have_pend;
   logic [15:0] m_pend;

   pc_sequencer #(
      .RESET_PC (16'h0000),
      .CNT_W    (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt_req        (halt_req),
      .pc              (pc),
      .pc_plus2        (pc_plus2),
      .halted          (halted),
      .err             (err),
      .retired         (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".pc_plus2"}, pc_plus2, m_pc + 16'd2);
      check({tag, ".retired"}, retired, m_ret);
      check({tag, ".err"}, {15'd0, err}, {15'd0, m_err});
      check({tag, ".halted"}, {15'd0, halted}, {15'd0, m_stopped_halt});
   endtask

   task automatic do_reset(input logic st, input logic rv, input logic [15:0] tgt);
      rst             = 1'b1;
      stall           = st;
      redirect_valid  = rv;
      redirect_target = tgt;
      halt_req        = 1'b0;
      m_pc            = 16'h0000;
      m_ret           = 16'd0;
      m_err           = 1'b0;
      m_stopped_halt  = 1'b0;
      m_stopped_err   = 1'b0;
      m_have_pend     = 1'b0;
      m_pend          = 16'h0000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("reset");
   endtask

   task automatic step(input string tag, input logic st, input logic rv, input logic [15:0] tgt,
                       input logic hr);
      logic        go;
      logic [15:0] dest;
      stall           = st;
      redirect_valid  = rv;
      redirect_target = tgt;
      halt_req        = hr;
      if (!m_stopped_halt && !m_stopped_err) begin
         if (st) begin
            if (rv) begin
               m_have_pend = 1'b1;
               m_pend      = tgt;
            end
         end else if (hr) begin
            m_stopped_halt = 1'b1;
            m_ret          = m_ret + 16'd1;
            m_have_pend    = 1'b0;
         end else begin
            go   = rv || m_have_pend;
            dest = rv ? tgt : m_pend;
            m_have_pend = 1'b0;
            if (go && (dest % 2 == 1)) begin
               m_stopped_err = 1'b1;
               m_err         = 1'b1;
            end else begin
               m_pc  = go ? dest : m_pc + 16'd2;
               m_ret = m_ret + 16'd1;
            end
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [15:0] t;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0;
      #2;
      do_reset(1'b0, 1'b0, 16'h0);

      for (int i = 0; i < 4; i++) step("free", 1'b0, 1'b0, 16'h0, 1'b0);
      check("free.pc8", pc, 16'h0008);
      check("free.ret4", retired, 16'd4);

      step("to10", 1'b0, 1'b1, 16'h0010, 1'b0);
      step("br100", 1'b0, 1'b1, 16'h0100, 1'b0);
      check("br100.pc", pc, 16'h0100);
      step("stall_rd", 1'b1, 1'b1, 16'h0200, 1'b0);
      step("stall2", 1'b1, 1'b0, 16'h0000, 1'b0);
      step("stall3", 1'b1, 1'b0, 16'h0000, 1'b0);
      check("stall.pc", pc, 16'h0100);
      step("unstall", 1'b0, 1'b0, 16'h0000, 1'b0);
      check("pend.pc", pc, 16'h0200);

      step("toFFFE", 1'b0, 1'b1, 16'hFFFE, 1'b0);
      step("wrap", 1'b0, 1'b0, 16'h0000, 1'b0);
      check("wrap.pc", pc, 16'h0000);

      step("to20", 1'b0, 1'b1, 16'h0020, 1'b0);
      step("halt", 1'b0, 1'b1, 16'h0040, 1'b1);
      check("halt.halted", {15'd0, halted}, 16'd1);
      for (int i = 0; i < 10; i++)
         step("halted", 1'(i % 2), 1'b1, 16'($urandom), 1'($urandom_range(1)));
      check("halt.frozen", pc, 16'h0020);
      do_reset(1'b0, 1'b0, 16'h0);

      step("mis", 1'b0, 1'b1, 16'h0031, 1'b0);
      check("mis.err", {15'd0, err}, 16'd1);
      for (int i = 0; i < 4; i++) step("mis_sticky", 1'b0, 1'b1, 16'h0100, 1'b0);
      do_reset(1'b0, 1'b0, 16'h0);
      step("mis_pend_st", 1'b1, 1'b1, 16'h0033, 1'b0);
      step("mis_pend", 1'b0, 1'b0, 16'h0000, 1'b0);
      check("mis_pend.err", {15'd0, err}, 16'd1);

      do_reset(1'b0, 1'b0, 16'h0);
      step("rp_stall", 1'b1, 1'b1, 16'h0300, 1'b0);
      do_reset(1'b1, 1'b1, 16'h0300);
      step("rp_adv", 1'b0, 1'b0, 16'h0000, 1'b0);
      check("rp_adv.pc", pc, 16'h0002);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(39) == 0) begin
            do_reset(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom));
         end else begin
            t = 16'($urandom);
            if ($urandom_range(7) != 0) t[0] = 1'b0;
            step("rand", ($urandom_range(9) < 3), ($urandom_range(9) < 2), t,
                 ($urandom_range(49) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
